// File: rtl/addsub_pkg.sv
// Shared definitions for the hybrid_cla self-test controller.
//   - bist_state_e : controller FSM states
//   - vec_t        : one test vector {a, b, c0}
//   - addsub_golden: reference model returning {carry, v, s}
//   - AS_W         : operand width; it must equal the hybrid_cla width
package addsub_pkg;

  localparam int          AS_W         = 15;
  localparam int          NUM_DIRECTED = 8;
  // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } bist_state_e;

  typedef struct packed {
    logic [AS_W-1:0] a;
    logic [AS_W-1:0] b;
    logic            c0;
  } vec_t;

  // Reference add/subtract.
  // Carry is the raw carry-out, so a subtract with no borrow gives carry=1.
  function automatic logic [AS_W+1:0] addsub_golden(input logic [AS_W-1:0] a,
                                                    input logic [AS_W-1:0] b,
                                                    input logic            c0);
    logic [AS_W-1:0] bx;
    logic [AS_W:0]   sum;
    logic            v;
    bx  = c0 ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{AS_W{1'b0}}, c0};
    v   = (a[AS_W-1] == bx[AS_W-1]) & (sum[AS_W-1] != a[AS_W-1]);
    return {sum[AS_W], v, sum[AS_W-1:0]};
  endfunction

endpackage

// File: rtl/addsub_bist_ctrl_if.sv
// Bus between the self-test controller and hybrid_cla.
//   master (controller): drives dut_a, dut_b and dut_c0; samples dut_s, dut_carry and dut_v.
//   slave  (adder)     : the reverse direction.
interface addsub_bist_ctrl_if #(
  parameter int WIDTH = 15
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_c0;
  logic [WIDTH-1:0] dut_s;
  logic             dut_carry;
  logic             dut_v;

  modport master (output dut_a, dut_b, dut_c0, input dut_s, dut_carry, dut_v);
  modport slave  (input dut_a, dut_b, dut_c0, output dut_s, dut_carry, dut_v);
endinterface

// File: rtl/addsub_vector_rom.sv
// Directed-vector table for the self-test controller.
//   idx_i : vector index 0..7
//   vec_o : {a, b, c0}; entries 0-3 add and entries 4-7 subtract
// The vectors cover a plain add, positive overflow, carry-out with and
// without overflow, and borrow and overflow on subtract.
module addsub_vector_rom
  import addsub_pkg::*;
(
  input  logic [2:0] idx_i,
  output vec_t       vec_o
);

  always_comb begin
    vec_o = '0;
    unique case (idx_i)
      3'd0: vec_o = '{a: 15'h002F, b: 15'h001F, c0: 1'b0};
      3'd1: vec_o = '{a: 15'h3FFF, b: 15'h0001, c0: 1'b0};
      3'd2: vec_o = '{a: 15'h6000, b: 15'h6000, c0: 1'b0};
      3'd3: vec_o = '{a: 15'h4000, b: 15'h4000, c0: 1'b0};
      3'd4: vec_o = '{a: 15'h0007, b: 15'h0801, c0: 1'b1};
      3'd5: vec_o = '{a: 15'h3FD1, b: 15'h4003, c0: 1'b1};
      3'd6: vec_o = '{a: 15'h002F, b: 15'h001F, c0: 1'b1};
      3'd7: vec_o = '{a: 15'h5FD1, b: 15'h201F, c0: 1'b1};
      default: vec_o = '0;
    endcase
  end

endmodule

// File: rtl/addsub_bist_ctrl.sv
// On-chip self-test controller for the hybrid_cla adder/subtractor.
// It applies NUM_VECTORS vectors. Vectors 0-7 are directed; the rest are
// pseudo-random from a 16-bit LFSR. Each result is checked against a golden
// model, and the block reports pass/fail, a saturating error count and the
// first failing vector.
//   clk, rst     : clock and synchronous active-high reset
//   start_i      : one-cycle pulse; starts a run from IDLE or DONE
//   bus          : operands out, and sum/carry/overflow in (master modport)
//   busy_o       : high while a run is in progress
//   done_o       : high in DONE
//   pass_o       : valid with done_o; set when no mismatch was seen
//   err_count_o  : saturating mismatch count
//   fail_idx_o   : index of the first failing vector
//   fail_exp_o   : expected {carry, v, s} at the first failure
//   fail_got_o   : observed {carry, v, s} at the first failure
module addsub_bist_ctrl
  import addsub_pkg::*;
#(
  parameter int          WIDTH         = AS_W,
  parameter int          NUM_VECTORS   = 64,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          ERR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  addsub_bist_ctrl_if.master    bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_W-1:0]      err_count_o,
  output logic [15:0]           fail_idx_o,
  output logic [WIDTH+1:0]      fail_exp_o,
  output logic [WIDTH+1:0]      fail_got_o
);

  localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  bist_state_e        state_q, state_d;
  logic [15:0]        idx_q, idx_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               c0_q, c0_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [15:0]        fidx_q, fidx_d;
  logic [WIDTH+1:0]   fexp_q, fexp_d, fgot_q, fgot_d;
  logic               pass_q, pass_d;

  vec_t               rom_vec;
  logic [WIDTH+1:0]   gold, got;
  logic               mismatch;

  addsub_vector_rom u_rom (
    .idx_i (idx_q[2:0]),
    .vec_o (rom_vec)
  );

  // The golden model uses the registered operands, so it is stable for the
  // whole settle/check window.
  assign gold     = addsub_golden(a_q, b_q, c0_q);
  assign got      = {bus.dut_carry, bus.dut_v, bus.dut_s};
  assign mismatch = (got != gold);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    lfsr_d   = lfsr_q;
    a_d      = a_q;
    b_d      = b_q;
    c0_d     = c0_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fexp_d   = fexp_q;
    fgot_d   = fgot_q;
    pass_d   = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A start from DONE is a rerun. Clear all run results so that
        // nothing from the previous run is carried over.
        if (start_i) begin
          state_d = DRIVE;
          idx_d   = '0;
          lfsr_d  = LFSR_SEED;
          err_d   = '0;
          fidx_d  = '0;
          fexp_d  = '0;
          fgot_d  = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (idx_q < 16'(NUM_DIRECTED)) begin
          a_d  = rom_vec.a;
          b_d  = rom_vec.b;
          c0_d = rom_vec.c0;
        end else begin
          // The operands come from the current LFSR value. The register
          // steps once for each random vector.
          a_d    = lfsr_q[14:0];
          b_d    = {lfsr_q[7:0], lfsr_q[15:9]};
          c0_d   = lfsr_q[15];
          lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q + SET_W'(1);
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          // The count saturates and never returns to zero within a run, so a
          // zero count means that this is the first failure.
          if (err_q == '0) begin
            fidx_d = idx_q;
            fexp_d = gold;
            fgot_d = got;
          end
        end
        if (idx_q == 16'(NUM_VECTORS - 1)) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      lfsr_q   <= LFSR_SEED;
      a_q      <= '0;
      b_q      <= '0;
      c0_q     <= 1'b0;
      err_q    <= '0;
      fidx_q   <= '0;
      fexp_q   <= '0;
      fgot_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      lfsr_q   <= lfsr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c0_q     <= c0_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fexp_q   <= fexp_d;
      fgot_q   <= fgot_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.dut_a   = a_q;
  assign bus.dut_b   = b_q;
  assign bus.dut_c0  = c0_q;
  assign busy_o      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_idx_o  = fidx_q;
  assign fail_exp_o  = fexp_q;
  assign fail_got_o  = fgot_q;

endmodule

// File: tb/tb_addsub_bist_ctrl.sv
// Directed bench for addsub_bist_ctrl.
// A behavioural adder stands in for hybrid_cla and can inject two faults:
// S[0] stuck at 0, or V inverted. Instance A uses the default parameters.
// Instance B uses 300 vectors, to check that the error counter saturates.
module tb_addsub_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] fault_a = 2'd0, fault_b = 2'd0;

  always #5 clk = ~clk;

  addsub_bist_ctrl_if #(.WIDTH(15)) ifa ();
  addsub_bist_ctrl_if #(.WIDTH(15)) ifb ();

  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0]  err_a, err_b;
  logic [15:0] fidx_a, fidx_b;
  logic [16:0] fexp_a, fgot_a, fexp_b, fgot_b;

  addsub_bist_ctrl u_dut (
    .clk(clk), .rst(rst), .start_i(start_a), .bus(ifa),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
    .fail_idx_o(fidx_a), .fail_exp_o(fexp_a), .fail_got_o(fgot_a)
  );

  addsub_bist_ctrl #(.NUM_VECTORS(300)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .bus(ifb),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
    .fail_idx_o(fidx_b), .fail_exp_o(fexp_b), .fail_got_o(fgot_b)
  );

  // Adder model. Overflow is taken from a sign-extended sum: bits 15 and 14
  // differ exactly when the 15-bit signed result overflows.
  function automatic logic [16:0] adder_model(input logic [14:0] a, input logic [14:0] b,
                                              input logic c0, input logic [1:0] fault);
    logic [14:0] bx;
    logic [15:0] u;
    logic [15:0] sg;
    logic        v;
    bx = b ^ {15{c0}};
    u  = {1'b0, a} + {1'b0, bx} + {15'd0, c0};
    sg = {a[14], a} + {bx[14], bx} + {15'd0, c0};
    v  = sg[15] ^ sg[14];
    if (fault == 2'd1) u[0] = 1'b0;
    if (fault == 2'd2) v = ~v;
    return {u[15], v, u[14:0]};
  endfunction

  assign {ifa.dut_carry, ifa.dut_v, ifa.dut_s} = adder_model(ifa.dut_a, ifa.dut_b, ifa.dut_c0, fault_a);
  assign {ifb.dut_carry, ifb.dut_v, ifb.dut_s} = adder_model(ifb.dut_a, ifb.dut_b, ifb.dut_c0, fault_b);

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected {a,b,c0}: 8 directed vectors, then the first two LFSR vectors
  // (ACE1, then 59C3 after one step).
  logic [30:0] exp_ops [10];
  initial begin
    exp_ops[0] = {15'h002F, 15'h001F, 1'b0};
    exp_ops[1] = {15'h3FFF, 15'h0001, 1'b0};
    exp_ops[2] = {15'h6000, 15'h6000, 1'b0};
    exp_ops[3] = {15'h4000, 15'h4000, 1'b0};
    exp_ops[4] = {15'h0007, 15'h0801, 1'b1};
    exp_ops[5] = {15'h3FD1, 15'h4003, 1'b1};
    exp_ops[6] = {15'h002F, 15'h001F, 1'b1};
    exp_ops[7] = {15'h5FD1, 15'h201F, 1'b1};
    exp_ops[8] = {15'h2CE1, 15'h70D6, 1'b1};
    exp_ops[9] = {15'h59C3, 15'h61AC, 1'b0};
  end

  // Pulse start on instance A and count the clocks until done. Optionally,
  // pulse start again at cycle pulse_at, and check the operands of the first
  // ten vectors.
  task automatic run_a(input int pulse_at, input bit chk_ops, output int cyc);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      start_a = (cyc == pulse_at);
      if (chk_ops && (cyc % 4 == 1) && (cyc / 4 < 10))
        chk($sformatf("ops%0d", cyc / 4), {1'b0, ifa.dut_a, ifa.dut_b, ifa.dut_c0},
            {1'b0, exp_ops[cyc / 4]});
      if (cyc < 256) chk("busy_in_run", 32'(busy_a), 32'd1);
    end
    start_a = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ops",  {1'b0, ifa.dut_a, ifa.dut_b, ifa.dut_c0}, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err",  32'(err_a),  32'd0);
    chk("rst_fidx", 32'(fidx_a), 32'd0);
    chk("rst_fexp", 32'(fexp_a), 32'd0);
    chk("rst_fgot", 32'(fgot_a), 32'd0);

    // Clean run: operand sequence, run length and verdict
    run_a(-1, 1'b1, cyc);
    chk("clean_len",  32'(cyc),    32'd256);
    chk("clean_pass", 32'(pass_a), 32'd1);
    chk("clean_err",  32'(err_a),  32'd0);
    chk("clean_done", 32'(done_a), 32'd1);

    // Start pulsed mid-run is ignored
    run_a(10, 1'b0, cyc);
    chk("midstart_len",  32'(cyc),    32'd256);
    chk("midstart_pass", 32'(pass_a), 32'd1);

    // V inverted: every vector fails; capture is at idx 0
    fault_a = 2'd2;
    run_a(-1, 1'b0, cyc);
    chk("vinv_err",  32'(err_a),  32'd64);
    chk("vinv_pass", 32'(pass_a), 32'd0);
    chk("vinv_fidx", 32'(fidx_a), 32'd0);
    chk("vinv_fexp", 32'(fexp_a), 32'h0004E);
    chk("vinv_fgot", 32'(fgot_a), 32'h0804E);

    // Rerun from DONE clears the results on the start edge
    fault_a = 2'd0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("rerun_err",  32'(err_a),  32'd0);
    chk("rerun_fidx", 32'(fidx_a), 32'd0);
    chk("rerun_fexp", 32'(fexp_a), 32'd0);
    chk("rerun_done", 32'(done_a), 32'd0);
    chk("rerun_pass", 32'(pass_a), 32'd0);
    cyc = 0;
    while (!done_a && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rerun_len",  32'(cyc),    32'd256);
    chk("rerun_ok",   32'(pass_a), 32'd1);

    // S[0] stuck at 0. Every directed sum is even, so the first capture is
    // random vector 8: 2CE1 - 70D6 = 3C0B.
    fault_a = 2'd1;
    run_a(-1, 1'b0, cyc);
    chk("s0_fidx",  32'(fidx_a), 32'd8);
    chk("s0_fexp",  32'(fexp_a), 32'h03C0B);
    chk("s0_fgot",  32'(fgot_a), 32'h03C0A);
    chk("s0_pass",  32'(pass_a), 32'd0);
    chk("s0_errnz", 32'(err_a != 8'd0), 32'd1);
    fault_a = 2'd0;

    // Reset mid-SETTLE aborts the run; the next run replays from the seed
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_ops",  {1'b0, ifa.dut_a, ifa.dut_b, ifa.dut_c0}, 32'd0);
    chk("abort_res",  {14'd0, done_a, pass_a, err_a, fidx_a}, 32'd0);
    chk("abort_fail", 32'(fexp_a | fgot_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_a(-1, 1'b1, cyc);
    chk("replay_len",  32'(cyc),    32'd256);
    chk("replay_pass", 32'(pass_a), 32'd1);

    // 300 vectors all failing: the counter saturates at 255
    fault_b = 2'd2;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("sat_len",  32'(cyc),    32'd1200);
    chk("sat_err",  32'(err_b),  32'd255);
    chk("sat_pass", 32'(pass_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
